dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter WAIT_CYCLES, default 1, number of wait-state cycles inserted per access (0..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  1  access request, sampled only when idle.
REQ-007 we  in  1  1 = store, 0 = load.
REQ-008 size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-010 addr  in  ADDR_W+2  byte address; bits [1:0] select the lane.
REQ-011 wdata  in  32  store data, right-aligned.
REQ-012 rdata  out  32  formatted load data.
REQ-013 ack  out  1  one-cycle completion pulse.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.
REQ-015 err  out  1  misalignment flag, valid with ack.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; IDLE->WAIT on req, WAIT->RESP when the wait counter reaches 0, RESP->IDLE unconditionally.
REQ-017 On the accepting edge, the block SHALL latch we, size, sign_ext, addr and wdata, and load the counter with WAIT_CYCLES.
REQ-018 The counter SHALL decrement once per WAIT cycle; the memory access SHALL be issued on the edge leaving WAIT.
REQ-019 ack SHALL be high for exactly one cycle, WAIT_CYCLES+2 rising edges after the accepting edge.
REQ-020 req SHALL be ignored while busy; the next request can be accepted on the first edge after the ack cycle.
REQ-021 Lanes SHALL be little-endian: byte n of the word occupies bits [8n+7:8n].
REQ-022 Stores SHALL write only the addressed lanes: byte = 1 lane, half = 2 lanes at addr[1], word = all 4 lanes; the other lanes are preserved.
REQ-023 Loads SHALL right-align the addressed lanes and extend them to 32 bits according to sign_ext; word loads ignore sign_ext.
REQ-024 rdata SHALL update only in the ack cycle of a successful load, and hold its value otherwise (including across stores).
REQ-025 size=11 SHALL behave as a word access unless DMEM_MISALIGN_TRAP_EN is defined.

Reset
REQ-026 When rst_n is low, the block SHALL force state=IDLE, counter=0, rdata=0, ack=0, busy=0 and err=0 immediately.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 A reset asserted during WAIT SHALL abandon the access; a pending store SHALL NOT commit.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: half at odd addr, word at addr[1:0]!=0, or size=11 SHALL issue no memory access and SHALL ack with err=1 at normal latency; rdata is unchanged.
REQ-030 Macro undefined: the block SHALL force address bits below the access size to 0 (aligned down), and err SHALL be tied to 0.

Structure
REQ-031 Package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state typedef and the lane-mask function.
REQ-032 Sub-module dmem_bank SHALL hold the storage: 2**ADDR_W x 32, per-byte write enables, synchronous read, no reset.
REQ-033 The lane steering and extension logic SHALL live in dmem_ctrl.

Verification (ADDR_W=10, WAIT_CYCLES=1)
REQ-034 Store word 0x8000001F at 0x010, then load word at 0x010 -> rdata=0x8000001F; ack exactly 3 edges after acceptance; busy high for 3 cycles.
REQ-035 Store byte 0xA5 at 0x011, then load word at 0x010 -> 0x8000A51F; lb at 0x011 -> 0xFFFFFFA5; lbu at 0x011 -> 0x000000A5.
REQ-036 Store half 0x1234 at 0x012 -> lh at 0x012 = 0x00001234; load word at 0x010 = 0x1234A51F.
REQ-037 Load word at 0x013 -> with DMEM_MISALIGN_TRAP_EN: err=1 and rdata unchanged; without it: rdata=0x1234A51F and err=0.
REQ-038 Store 0x11111111 at 0x020, then store 0xDEADBEEF at 0x020 with rst_n pulsed low during WAIT -> all outputs 0 during reset; a later load at 0x020 returns 0x11111111.
REQ-039 Hold req high continuously with new operands each cycle -> only one access per ack; second acceptance on the edge after ack; no request is double-counted.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: access-size encodings,
// FSM state type and lane helper functions.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Byte-lane enables for an access of the given size at an aligned lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // True when the address is not naturally aligned for the access size;
  // the reserved size is always treated as illegal here.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Contents are intentionally not reset.
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(2**ADDR_W)-1];
  logic [31:0] r_rdata;

  // Enabled access: write selected byte lanes, capture the old word for reads.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one byte/half/word load or store at a time,
// inserts WAIT_CYCLES wait states, then acknowledges with formatted load data.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned or reserved-size
// accesses are dropped and acknowledged with err=1. Without it, addresses are
// aligned down to the access size and err is constant 0.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_sext;
  logic [1:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_ack;
  logic              r_busy;

  logic        w_access;
  logic        w_trap;
  logic [1:0]  w_lane;
  logic [3:0]  w_mask;
  logic        w_bank_en;
  logic [3:0]  w_bank_be;
  logic [31:0] w_bank_wdata;
  logic [31:0] w_bank_q;
  logic [31:0] w_shift;
  logic [31:0] w_load;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(r_size, r_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // The access fires on the edge that leaves WAIT; trapped accesses never reach the bank.
  assign w_access  = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_bank_en = w_access && !w_trap;
  assign w_mask    = lane_mask(r_size, w_lane);
  assign w_bank_be = r_we ? w_mask : 4'b0000;
  assign w_shift   = w_bank_q >> {w_lane, 3'b000};

  // Starting lane after aligning the byte address down to the access size.
  always_comb begin
    w_lane = 2'b00;
    case (r_size)
      SZ_BYTE: w_lane = r_addr[1:0];
      SZ_HALF: w_lane = {r_addr[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
  end

  // Replicate right-aligned store data across lanes; byte enables pick the target.
  always_comb begin
    w_bank_wdata = r_wdata;
    case (r_size)
      SZ_BYTE: w_bank_wdata = {4{r_wdata[7:0]}};
      SZ_HALF: w_bank_wdata = {2{r_wdata[15:0]}};
      default: w_bank_wdata = r_wdata;
    endcase
  end

  // Right-align the loaded lanes and sign- or zero-extend sub-word loads.
  always_comb begin
    w_load = w_shift;
    case (r_size)
      SZ_BYTE: w_load = {{24{r_sext & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: w_load = {{16{r_sext & w_shift[15]}}, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req) w_next = ST_WAIT; else w_next = ST_IDLE;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP; else w_next = ST_WAIT;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, wait counter and operand capture on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && req) begin
        r_cnt   <= LP_WAIT;
        r_we    <= we;
        r_sext  <= sign_ext;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Registered handshake outputs and load data, which only moves on a good load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack  <= (r_state == ST_RESP);
      r_busy <= (w_next != ST_IDLE);
      if ((r_state == ST_RESP) && !r_we && !w_trap) begin
        r_rdata <= w_load;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic r_err;

  // Error flag rides along with ack for trapped accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == ST_RESP) && w_trap;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign busy  = r_busy;

  dmem_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_bank_en),
    .i_be    (w_bank_be),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (w_bank_wdata),
    .o_rdata (w_bank_q)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (ADDR_W=10, WAIT_CYCLES=1): directed
// scenarios plus random traffic against a byte-array reference model.
module tb_dmem_ctrl;

  localparam int ADDR_W = 10;
  localparam int WAITS  = 1;
  localparam int REGION = 256;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mm [0:4095];
  logic [31:0] exp_rdata;
  logic        exp_err;

  dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, natural alignment by arithmetic.
  task automatic model_op(input bit w, input logic [1:0] sz, input bit sx,
                          input logic [11:0] a, input logic [31:0] wd);
    int nb;
    int ea;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(a) % nb) != 0 || sz == 2'd3) begin
      exp_err = 1'b1;
      return;
    end
`endif
    exp_err = 1'b0;
    ea = int'(a) - (int'(a) % nb);
    if (w) begin
      for (int i = 0; i < nb; i++) mm[ea + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[ea + i];
      if (sx && nb < 4 && v[8*nb-1]) begin
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      exp_rdata = v;
    end
  endtask

  task automatic drive(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [11:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
  endtask

  // One access; called #1 after an edge with the DUT idle. Returns in the ack cycle.
  task automatic do_op(input bit w, input logic [1:0] sz, input bit sx,
                       input logic [11:0] a, input logic [31:0] wd, input bit hold);
    int n;
    int busy_cnt;
    drive(w, sz, sx, a, wd);
    @(posedge clk); #1;
    model_op(w, sz, sx, a, wd);
    chk_eq("ack_pulse", {31'd0, ack}, 32'd0);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    if (!hold) req = 1'b0;
    while (!ack && n < 20) begin
      if (hold) drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                      12'($urandom_range(0, REGION - 1)), $urandom);
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
    chk_eq("latency", n, WAITS + 2);
    chk_eq("busy_cycles", busy_cnt, WAITS + 2);
    chk_eq("rdata", rdata, exp_rdata);
    chk_eq("err", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = 12'd0; wdata = 32'd0;
    exp_rdata = 32'd0; exp_err = 1'b0;
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    #12;
    chk_eq("rst_rdata", rdata, 32'd0);
    chk_eq("rst_ack", {31'd0, ack}, 32'd0);
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Initialise the exercised region so every later load reads known data.
    for (int i = 0; i < REGION; i += 4) do_op(1'b1, 2'd2, 1'b0, 12'(i), $urandom, 1'b0);

    do_op(1'b1, 2'd2, 1'b0, 12'h010, 32'h8000001F, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b0);
    chk_eq("lw_010_a", rdata, 32'h8000001F);

    do_op(1'b1, 2'd0, 1'b0, 12'h011, 32'h000000A5, 1'b0);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b0);
    chk_eq("lw_010_b", rdata, 32'h8000A51F);
    do_op(1'b0, 2'd0, 1'b1, 12'h011, 32'd0, 1'b0);
    chk_eq("lb_011", rdata, 32'hFFFFFFA5);
    do_op(1'b0, 2'd0, 1'b0, 12'h011, 32'd0, 1'b0);
    chk_eq("lbu_011", rdata, 32'h000000A5);

    do_op(1'b1, 2'd1, 1'b0, 12'h012, 32'h00001234, 1'b0);
    do_op(1'b0, 2'd1, 1'b1, 12'h012, 32'd0, 1'b0);
    chk_eq("lh_012", rdata, 32'h00001234);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 1'b0);
    chk_eq("lw_010_c", rdata, 32'h1234A51F);

    do_op(1'b0, 2'd2, 1'b0, 12'h013, 32'd0, 1'b0);
    chk_eq("lw_013", rdata, 32'h1234A51F);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk_eq("lw_013_err", {31'd0, err}, 32'd1);
`else
    chk_eq("lw_013_err", {31'd0, err}, 32'd0);
`endif

    // Reset during WAIT abandons the store.
    do_op(1'b1, 2'd2, 1'b0, 12'h020, 32'h11111111, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 12'h020, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk_eq("mid_busy", {31'd0, busy}, 32'd1);
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_rdata", rdata, 32'd0);
    chk_eq("mid_rst_ack", {31'd0, ack}, 32'd0);
    chk_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("mid_rst_err", {31'd0, err}, 32'd0);
    #1 rst_n = 1'b1;
    exp_rdata = 32'd0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 2'd2, 1'b0, 12'h020, 32'd0, 1'b0);
    chk_eq("lw_020", rdata, 32'h11111111);

    // Random traffic with req dropped after acceptance.
    for (int k = 0; k < 150; k++)
      do_op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
            12'($urandom_range(0, REGION - 1)), $urandom, 1'b0);

    // Random traffic with req held high and operands changing every cycle.
    for (int k = 0; k < 100; k++)
      do_op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
            12'($urandom_range(0, REGION - 1)), $urandom, 1'b1);
    req = 1'b0;

    // Read back the whole region to catch any stray writes.
    for (int i = 0; i < REGION; i += 4) do_op(1'b0, 2'd2, 1'b0, 12'(i), 32'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
